// File: rtl/sensor_pkg.sv
// Shared types and default constants for the sensor monitor slice.
package sensor_pkg;

    typedef enum logic [1:0] {
        OK    = 2'd0,
        ALARM = 2'd1,
        HOLD  = 2'd2
    } mon_state_t;

    localparam int         DEF_NUM_SENSORS = 4;
    localparam int         DEF_DEBOUNCE    = 4;
    localparam logic [3:0] DEF_CRIT_MASK   = 4'b0001;
    localparam int         DEF_MIN_FAULTS  = 2;
    localparam int         DEF_CNT_WIDTH   = 8;

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: two-flop synchroniser followed by a debounce counter
// that flips the stable bit after DEBOUNCE consecutive differing samples.
module sensor_debounce
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic n_rst,
    input  logic din,
    output logic stable
);

    localparam int            CW   = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          meta_q;
    logic          sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] dcnt_q, dcnt_d;

    // Any sample equal to the stable value restarts the count, so short pulses are dropped.
    always_comb begin
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        if (sync_q == stable_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == LAST) begin
            stable_d = ~stable_q;
            dcnt_d   = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            dcnt_q   <= '0;
        end else begin
            meta_q   <= din;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/sensor_monitor.sv
// Debounced multi-sensor fault monitor: critical/threshold fault rule feeding
// an OK/ALARM/HOLD state machine with sticky flag and saturating event counter.
module sensor_monitor
    import sensor_pkg::*;
#(
    parameter int                     NUM_SENSORS = DEF_NUM_SENSORS,
    parameter int                     DEBOUNCE    = DEF_DEBOUNCE,
    parameter logic [NUM_SENSORS-1:0] CRIT_MASK   = NUM_SENSORS'(DEF_CRIT_MASK),
    parameter int                     MIN_FAULTS  = DEF_MIN_FAULTS,
    parameter int                     CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NUM_SENSORS-1:0] sensors,
    input  logic                   clear,
    output logic [NUM_SENSORS-1:0] stable,
    output logic                   error,
    output logic                   error_sticky,
    output logic [CNT_WIDTH-1:0]   fault_count
);

    localparam int                   PW      = $clog2(NUM_SENSORS + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_SENSORS-1:0] stable_w;

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
        sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
            .clk    (clk),
            .n_rst  (n_rst),
            .din    (sensors[i]),
            .stable (stable_w[i])
        );
    end

    function automatic logic [PW-1:0] popcount(input logic [NUM_SENSORS-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    mon_state_t             state_q, state_d;
    logic                   error_q, error_d;
    logic                   sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   cond;
    logic                   entry;

    assign cond = (|(stable_w & CRIT_MASK)) ||
                  (popcount(stable_w & ~CRIT_MASK) >= PW'(MIN_FAULTS));

    always_comb begin
        state_d = state_q;
        case (state_q)
            OK:      if (cond) state_d = ALARM;
            ALARM:   if (!cond) state_d = HOLD;
            HOLD: begin
                if (cond)       state_d = ALARM;
                else if (clear) state_d = OK;
            end
            default: state_d = OK;
        endcase

        entry = (state_d == ALARM) && (state_q != ALARM);

        // A clear that coincides with a fresh ALARM entry still counts that entry.
        count_d = count_q;
        if (entry) begin
            if (clear)                count_d = CNT_WIDTH'(1);
            else if (count_q != CNT_MAX) count_d = count_q + 1'b1;
        end else if (clear && state_d != ALARM) begin
            count_d = '0;
        end

        error_d  = (state_d == ALARM);
        sticky_d = (state_d != OK);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= OK;
            error_q  <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            error_q  <= error_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign stable       = stable_w;
    assign error        = error_q;
    assign error_sticky = sticky_q;
    assign fault_count  = count_q;

endmodule

// File: tb/tb_sensor_monitor.sv
// Directed scoreboard bench for sensor_monitor with default parameters.
module tb_sensor_monitor;

    logic       clk;
    logic       n_rst;
    logic [3:0] sensors;
    logic       clear;
    logic [3:0] stable;
    logic       error;
    logic       error_sticky;
    logic [7:0] fault_count;

    sensor_monitor dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sensors      (sensors),
        .clear        (clear),
        .stable       (stable),
        .error        (error),
        .error_sticky (error_sticky),
        .fault_count  (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string       tag_q[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic push_exp(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_out(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    initial begin
        n_rst   = 1'b0;
        sensors = 4'b0000;
        clear   = 1'b0;

        // Reset state
        push_exp("rst_stable", 0);
        push_exp("rst_error", 0);
        push_exp("rst_sticky", 0);
        push_exp("rst_count", 0);
        repeat (2) @(negedge clk);
        check_out(32'(stable));
        check_out(32'(error));
        check_out(32'(error_sticky));
        check_out(32'(fault_count));
        n_rst = 1'b1;

        // Critical sensor: stable after 6 edges, error one edge later
        @(negedge clk);
        sensors = 4'b0001;
        push_exp("t1_stable_at5", 0);
        push_exp("t1_stable_at6", 1);
        push_exp("t1_error", 1);
        push_exp("t1_sticky", 1);
        push_exp("t1_count", 1);
        repeat (5) @(negedge clk);
        check_out(32'(stable));
        @(negedge clk);
        check_out(32'(stable));
        @(negedge clk);
        check_out(32'(error));
        check_out(32'(error_sticky));
        check_out(32'(fault_count));

        // Clear while ALARM with cond active is ignored
        clear = 1'b1;
        push_exp("alarm_clr_error", 1);
        push_exp("alarm_clr_sticky", 1);
        push_exp("alarm_clr_count", 1);
        @(negedge clk);
        clear = 1'b0;
        check_out(32'(error));
        check_out(32'(error_sticky));
        check_out(32'(fault_count));

        // Release: ALARM -> HOLD
        sensors = 4'b0000;
        push_exp("hold_error_at6", 1);
        push_exp("hold_error", 0);
        push_exp("hold_sticky", 1);
        push_exp("hold_count", 1);
        repeat (6) @(negedge clk);
        check_out(32'(error));
        @(negedge clk);
        check_out(32'(error));
        check_out(32'(error_sticky));
        check_out(32'(fault_count));

        // Clear from HOLD
        clear = 1'b1;
        push_exp("clr_sticky", 0);
        push_exp("clr_count", 0);
        push_exp("clr_error", 0);
        @(negedge clk);
        clear = 1'b0;
        check_out(32'(error_sticky));
        check_out(32'(fault_count));
        check_out(32'(error));

        // Glitch of 3 cycles never becomes stable
        sensors = 4'b0001;
        repeat (3) @(negedge clk);
        sensors = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            push_exp("glitch_stable", 0);
            push_exp("glitch_error", 0);
            @(negedge clk);
            check_out(32'(stable));
            check_out(32'(error));
        end

        // Single non-critical sensor is below threshold
        sensors = 4'b0100;
        push_exp("t2_stable", 4'b0100);
        push_exp("t2_error_single", 0);
        repeat (20) @(negedge clk);
        check_out(32'(stable));
        check_out(32'(error));

        // Second non-critical sensor reaches MIN_FAULTS
        sensors = 4'b1100;
        push_exp("t2_error_at6", 0);
        push_exp("t2_error_at7", 1);
        push_exp("t2_count", 1);
        repeat (6) @(negedge clk);
        check_out(32'(error));
        @(negedge clk);
        check_out(32'(error));
        check_out(32'(fault_count));

        sensors = 4'b0000;
        repeat (10) @(negedge clk);
        clear = 1'b1;
        push_exp("t2_clr_count", 0);
        push_exp("t2_clr_sticky", 0);
        @(negedge clk);
        clear = 1'b0;
        check_out(32'(fault_count));
        check_out(32'(error_sticky));

        // Saturation after 255 ALARM entries
        for (int k = 0; k < 255; k++) begin
            sensors = 4'b0001;
            repeat (8) @(negedge clk);
            sensors = 4'b0000;
            repeat (8) @(negedge clk);
        end
        push_exp("sat_count_255", 8'hFF);
        check_out(32'(fault_count));
        sensors = 4'b0001;
        push_exp("sat_count_256", 8'hFF);
        push_exp("sat_error", 1);
        repeat (8) @(negedge clk);
        check_out(32'(fault_count));
        check_out(32'(error));
        sensors = 4'b0000;
        push_exp("sat_hold_sticky", 1);
        push_exp("sat_hold_error", 0);
        repeat (8) @(negedge clk);
        check_out(32'(error_sticky));
        check_out(32'(error));

        // Clear coinciding with an ALARM entry from HOLD
        sensors = 4'b0001;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        push_exp("entry_clr_count", 1);
        push_exp("entry_clr_error", 1);
        @(negedge clk);
        clear = 1'b0;
        check_out(32'(fault_count));
        check_out(32'(error));

        // Asynchronous reset mid-ALARM
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        push_exp("arst_error", 0);
        push_exp("arst_sticky", 0);
        push_exp("arst_count", 0);
        push_exp("arst_stable", 0);
        check_out(32'(error));
        check_out(32'(error_sticky));
        check_out(32'(fault_count));
        check_out(32'(stable));
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        push_exp("rel_error_at6", 0);
        push_exp("rel_error_at7", 1);
        push_exp("rel_sticky", 1);
        push_exp("rel_count", 1);
        repeat (6) @(negedge clk);
        check_out(32'(error));
        @(negedge clk);
        check_out(32'(error));
        check_out(32'(error_sticky));
        check_out(32'(fault_count));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
